// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: 32-bit word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_latency_model_if.sv
// RAM-side bus between the memory controller (master) and the RAM responder (slave).
interface ram_latency_model_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_latency_model.sv
// Word-addressed RAM with a fixed access latency: LAT BUSY cycles, then one
// ACCESS cycle per transaction. A changed address/op restarts the count.
module ram_latency_model
  import cpu_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 8
) (
  input logic                 CLK,
  input logic                 RST,
  ram_latency_model_if.slave  ram
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  logic              active_q, active_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  word_t             lat_addr_q, lat_addr_d;
  logic              lat_op_q, lat_op_d;
  word_t             mem_q [DEPTH];

  logic              req, op, oor, match;
  logic [ADDR_W-1:0] idx;
  ramstate_t         state_c;
  logic              wr_en;

  always_comb begin
    req   = ram.ramREN ^ ram.ramWEN;
    op    = ram.ramWEN;
    idx   = ram.ramaddr[ADDR_W+1:2];
    oor   = |ram.ramaddr[31:ADDR_W+2];
    match = active_q && (ram.ramaddr == lat_addr_q) && (op == lat_op_q);

    if ((ram.ramREN && ram.ramWEN) || (req && oor)) state_c = ERROR;
    else if (!req)                                  state_c = FREE;
    else if (match && cnt_q == '0)                  state_c = ACCESS;
    else                                            state_c = BUSY;
  end

  assign ram.ramstate = state_c;
  assign ram.ramload  = (state_c == ACCESS && ram.ramREN) ? mem_q[idx] : '0;

  // NOTE: next-state logic assigns every _d a hold value first, so no path can infer a latch.
  always_comb begin
    active_d   = active_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_op_d   = lat_op_q;
    wr_en      = 1'b0;

    if (state_c == FREE || state_c == ERROR) begin
      active_d = 1'b0;
    end else if (!match) begin
      // New request, or address/op changed mid-transaction: restart the count.
      active_d   = 1'b1;
      lat_addr_d = ram.ramaddr;
      lat_op_d   = op;
      cnt_d      = CNT_W'(LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      wr_en    = lat_op_q;
      active_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q   <= 1'b0;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_op_q   <= 1'b0;
    end else begin
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      lat_op_q   <= lat_op_d;
    end
  end

  // NOTE: the memory is deliberately reset (a simulation model must come up zeroed), so it is built from flops, not a RAM macro.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= ram.ramstore;
    end
  end

endmodule

// File: tb/tb_ram_latency_model.sv
// Self-checking bench: LAT=2 and LAT=1 instances driven in lockstep and
// compared against a transaction-level reference model.
module tb_ram_latency_model;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  ren_v = 1'b0, wen_v = 1'b0;
  word_t addr_v = '0, store_v = '0;

  int total = 0;
  int bad   = 0;

  ram_latency_model_if bus2 ();
  ram_latency_model_if bus1 ();

  assign bus2.ramREN = ren_v;  assign bus1.ramREN = ren_v;
  assign bus2.ramWEN = wen_v;  assign bus1.ramWEN = wen_v;
  assign bus2.ramaddr = addr_v; assign bus1.ramaddr = addr_v;
  assign bus2.ramstore = store_v; assign bus1.ramstore = store_v;

  ram_latency_model #(.LAT(2), .ADDR_W(8)) u_lat2 (.CLK(CLK), .RST(RST), .ram(bus2));
  ram_latency_model #(.LAT(1), .ADDR_W(8)) u_lat1 (.CLK(CLK), .RST(RST), .ram(bus1));

  always #5 CLK = ~CLK;

  // Reference model: position of the current cycle inside a held, unchanged request.
  word_t mem_m    [2][256];
  bit    have_prev[2];
  word_t prev_addr[2];
  bit    prev_op  [2];
  int    prev_pos [2];
  bit    prev_acc [2];
  word_t last_load0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) mem_m[i][a] = '0;
      have_prev[i] = 1'b0;
    end
  endtask

  task automatic model_eval(input int i, output ramstate_t es, output word_t el, output int pos);
    bit req, op;
    req = ren_v ^ wen_v;
    op  = wen_v;
    pos = 0;
    if ((ren_v && wen_v) || (req && addr_v[31:10] != 0)) es = ERROR;
    else if (!req) es = FREE;
    else begin
      if (have_prev[i] && prev_addr[i] == addr_v && prev_op[i] == op && !prev_acc[i])
        pos = prev_pos[i] + 1;
      es = (pos == lat_of(i)) ? ACCESS : BUSY;
    end
    el = (es == ACCESS && ren_v) ? mem_m[i][addr_v[9:2]] : '0;
  endtask

  task automatic model_commit(input int i, input ramstate_t es, input int pos);
    if (es == FREE || es == ERROR) begin
      have_prev[i] = 1'b0;
    end else begin
      have_prev[i] = 1'b1;
      prev_addr[i] = addr_v;
      prev_op[i]   = wen_v;
      prev_pos[i]  = pos;
      prev_acc[i]  = (es == ACCESS);
      if (es == ACCESS && wen_v) mem_m[i][addr_v[9:2]] = store_v;
    end
  endtask

  task automatic check(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input word_t addr, input word_t store);
    ren_v = ren; wen_v = wen; addr_v = addr; store_v = store;
  endtask

  // Sample at the falling edge; want0/want1 are directed expectations (-1 = none).
  task automatic sample(input int want0, input int want1);
    ramstate_t es, obs_s;
    word_t     el, obs_l;
    int        pos;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      obs_s = (i == 0) ? bus2.ramstate : bus1.ramstate;
      obs_l = (i == 0) ? bus2.ramload  : bus1.ramload;
      model_eval(i, es, el, pos);
      check($sformatf("lat%0d_state", lat_of(i)), 32'(obs_s), 32'(es));
      check($sformatf("lat%0d_load", lat_of(i)), obs_l, el);
      if (i == 0 && want0 >= 0) check("lat2_directed", 32'(obs_s), 32'(want0));
      if (i == 1 && want1 >= 0) check("lat1_directed", 32'(obs_s), 32'(want1));
      model_commit(i, es, pos);
    end
    last_load0 = bus2.ramload;
  endtask

  task automatic step(input logic ren, input logic wen, input word_t addr, input word_t store,
                      input int want0 = -1, input int want1 = -1);
    drive(ren, wen, addr, store);
    sample(want0, want1);
    @(posedge CLK); #1;
  endtask

  initial begin
    int B, A, F, E;
    logic r_ren, r_wen;
    word_t r_addr;
    B = int'(BUSY); A = int'(ACCESS); F = int'(FREE); E = int'(ERROR);
    model_reset();

    // Reset state: outputs idle while RST is held.
    #2;
    check("reset_state2", 32'(bus2.ramstate), 32'(FREE));
    check("reset_state1", 32'(bus1.ramstate), 32'(FREE));
    check("reset_load2", bus2.ramload, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Write then read 0x10.
    step(0, 1, 32'h10, 32'hDEADBEEF, B, B);
    step(0, 1, 32'h10, 32'hDEADBEEF, B, A);
    step(0, 1, 32'h10, 32'hDEADBEEF, A, B);
    step(0, 0, 32'h0, 32'h0, F, F);
    step(1, 0, 32'h10, 32'h0, B, B);
    step(1, 0, 32'h10, 32'h0, B, A);
    step(1, 0, 32'h10, 32'h0, A, B);
    check("rd_deadbeef", last_load0, 32'hDEADBEEF);
    step(0, 0, 32'h0, 32'h0, F, F);

    // Address switch mid-BUSY, reading back mem[9].
    step(0, 1, 32'h24, 32'hCAFE0009, B, B);
    step(0, 1, 32'h24, 32'hCAFE0009, B, A);
    step(0, 1, 32'h24, 32'hCAFE0009, A, B);
    step(0, 0, 32'h0, 32'h0, F, F);
    step(1, 0, 32'h20, 32'h0, B, B);
    step(1, 0, 32'h24, 32'h0, B, B);
    step(1, 0, 32'h24, 32'h0, B, A);
    step(1, 0, 32'h24, 32'h0, A, B);
    check("switch_load", last_load0, 32'hCAFE0009);
    step(0, 0, 32'h0, 32'h0, F, F);

    // Held read across ACCESS.
    step(1, 0, 32'h8, 32'h0, B); step(1, 0, 32'h8, 32'h0, B);
    step(1, 0, 32'h8, 32'h0, A); step(1, 0, 32'h8, 32'h0, B);
    step(1, 0, 32'h8, 32'h0, B); step(1, 0, 32'h8, 32'h0, A);
    step(1, 0, 32'h8, 32'h0, B);
    step(0, 0, 32'h0, 32'h0, F, F);

    // Error cases: both strobes, then out-of-range address.
    step(1, 1, 32'h30, 32'h5555AAAA, E, E);
    step(1, 0, 32'h30, 32'h0, B, B);
    step(1, 0, 32'h30, 32'h0, B, A);
    step(1, 0, 32'h30, 32'h0, A, B);
    check("err_no_write", last_load0, 32'h0);
    step(1, 1, 32'h30, 32'h5555AAAA, E, E);
    step(0, 1, 32'h30, 32'h77, B, B);
    step(0, 1, 32'h30, 32'h77, B, A);
    step(0, 1, 32'h30, 32'h77, A, B);
    step(1, 0, 32'h1000, 32'h0, E, E);
    step(0, 1, 32'h1000, 32'h99, E, E);
    step(0, 0, 32'h0, 32'h0, F, F);

    // Asynchronous reset during the second BUSY of a write.
    step(0, 1, 32'h4, 32'h1234, B, B);
    drive(0, 1, 32'h4, 32'h1234);
    sample(B, A);
    drive(0, 0, 32'h4, 32'h1234);
    RST = 1'b1;
    #1;
    check("rst_state2", 32'(bus2.ramstate), 32'(FREE));
    check("rst_load2", bus2.ramload, 32'h0);
    check("rst_state1", 32'(bus1.ramstate), 32'(FREE));
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    step(1, 0, 32'h4, 32'h0, B, B);
    step(1, 0, 32'h4, 32'h0, B, A);
    step(1, 0, 32'h4, 32'h0, A, B);
    check("rst_discard", last_load0, 32'h0);
    step(1, 0, 32'h10, 32'h0, B, B);
    step(1, 0, 32'h10, 32'h0, B, A);
    step(1, 0, 32'h10, 32'h0, A, B);
    check("rst_mem_clear", last_load0, 32'h0);

    // Back-to-back read 0x0 then write 0x4, then dropped requests.
    step(1, 0, 32'h0, 32'h0, -1, B);
    step(0, 1, 32'h4, 32'hABCD, -1, B);
    step(0, 1, 32'h4, 32'hABCD, -1, A);
    step(0, 0, 32'h0, 32'h0, F, F);
    step(0, 1, 32'h8, 32'hBAD0, B, B);
    step(0, 0, 32'h8, 32'hBAD0, F, F);
    step(1, 0, 32'h8, 32'h0, B, B);
    step(1, 0, 32'h8, 32'h0, B, A);
    step(1, 0, 32'h8, 32'h0, A, B);
    check("drop_no_write", last_load0, 32'h0);

    // Randomized sticky requests against the model.
    r_ren = 0; r_wen = 0; r_addr = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(9))
          0, 1, 2, 3: begin r_ren = 1; r_wen = 0; end
          4, 5, 6, 7: begin r_ren = 0; r_wen = 1; end
          8:          begin r_ren = 1; r_wen = 1; end
          default:    begin r_ren = 0; r_wen = 0; end
        endcase
        r_addr = 32'($urandom_range(7)) << 2;
        if ($urandom_range(15) == 0) r_addr = r_addr | 32'h0000_0400;
      end
      step(r_ren, r_wen, r_addr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
